// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: handshake and data bus between one requester (master) and the arbiter (slave).
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  ack;
    logic                  valid;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output req, we, addr, din, input ack, valid, dout);
    modport slave  (input req, we, addr, din, output ack, valid, dout);
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between requesters A and B.
// Define ARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    portA,
    sram_port_arbiter_if.slave    portB,
    output logic                  ram_cen_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i
);

    logic                  ackA_q, ackA_d;
    logic                  ackB_q, ackB_d;
    logic                  ramCen_q, ramCen_d;
    logic                  ramWe_q, ramWe_d;
    logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_WIDTH-1:0] ramData_q, ramData_d;
    logic                  rdA_q, rdA_d;
    logic                  rdB_q, rdB_d;
    logic                  validA_q, validA_d;
    logic                  validB_q, validB_d;
    logic [DATA_WIDTH-1:0] doutA_q, doutA_d;
    logic [DATA_WIDTH-1:0] doutB_q, doutB_d;
    logic                  eligA, eligB;
    logic                  grantA, grantB;
`ifndef ARB_FIXED_PRIO_EN
    logic                  lastB_q, lastB_d;
`endif

    // A requester in its ack cycle is not eligible, which prevents double issue of one request.
    always_comb begin
        eligA = portA.req & ~ackA_q;
        eligB = portB.req & ~ackB_q;
`ifdef ARB_FIXED_PRIO_EN
        grantA = eligA;
        grantB = eligB & ~eligA;
`else
        grantA  = eligA & (~eligB | lastB_q);
        grantB  = eligB & (~eligA | ~lastB_q);
        lastB_d = grantB ? 1'b1 : (grantA ? 1'b0 : lastB_q);
`endif
        ackA_d    = grantA;
        ackB_d    = grantB;
        ramCen_d  = grantA | grantB;
        ramWe_d   = 1'b0;
        ramAddr_d = ramAddr_q;
        ramData_d = ramData_q;
        if (grantA) begin
            ramWe_d   = portA.we;
            ramAddr_d = portA.addr;
            ramData_d = portA.din;
        end else if (grantB) begin
            ramWe_d   = portB.we;
            ramAddr_d = portB.addr;
            ramData_d = portB.din;
        end
        rdA_d    = grantA & ~portA.we;
        rdB_d    = grantB & ~portB.we;
        validA_d = rdA_q;
        validB_d = rdB_q;
        // ram_q is only meaningful in the valid cycle; it is captured then and held afterwards.
        doutA_d  = validA_q ? ram_q_i : doutA_q;
        doutB_d  = validB_q ? ram_q_i : doutB_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ackA_q    <= 1'b0;
            ackB_q    <= 1'b0;
            ramCen_q  <= 1'b0;
            ramWe_q   <= 1'b0;
            ramAddr_q <= '0;
            ramData_q <= '0;
            rdA_q     <= 1'b0;
            rdB_q     <= 1'b0;
            validA_q  <= 1'b0;
            validB_q  <= 1'b0;
            doutA_q   <= '0;
            doutB_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            lastB_q   <= 1'b1;
`endif
        end else begin
            ackA_q    <= ackA_d;
            ackB_q    <= ackB_d;
            ramCen_q  <= ramCen_d;
            ramWe_q   <= ramWe_d;
            ramAddr_q <= ramAddr_d;
            ramData_q <= ramData_d;
            rdA_q     <= rdA_d;
            rdB_q     <= rdB_d;
            validA_q  <= validA_d;
            validB_q  <= validB_d;
            doutA_q   <= doutA_d;
            doutB_q   <= doutB_d;
`ifndef ARB_FIXED_PRIO_EN
            lastB_q   <= lastB_d;
`endif
        end
    end

    assign portA.ack   = ackA_q;
    assign portA.valid = validA_q;
    assign portA.dout  = doutA_d;
    assign portB.ack   = ackB_q;
    assign portB.valid = validB_q;
    assign portB.dout  = doutB_d;

    assign ram_cen_o  = ramCen_q;
    assign ram_we_o   = ramWe_q;
    assign ram_addr_o = ramAddr_q;
    assign ram_data_o = ramData_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random stimulus checked against a cycle-level arbitration model,
// with a behavioural SRAM hanging off the arbiter's RAM port.
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ramCen, ramWe;
    logic [9:0] ramAddr;
    logic [7:0] ramData;
    logic [7:0] ramQ;

    sram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) aBus ();
    sram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bBus ();

    sram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .portA      (aBus),
        .portB      (bBus),
        .ram_cen_o  (ramCen),
        .ram_we_o   (ramWe),
        .ram_addr_o (ramAddr),
        .ram_data_o (ramData),
        .ram_q_i    (ramQ)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] initVal(input logic [9:0] a);
        if (a == 10'h000) return 8'h11;
        if (a == 10'h3FF) return 8'hEE;
        return a[7:0] ^ 8'hA5;
    endfunction

    // Behavioural SRAM: unwritten locations read their initial pattern.
    logic [7:0] ramMem [1024];
    bit         ramWritten [1024];
    always @(posedge clk) begin
        if (ramCen) begin
            if (ramWe) begin
                ramMem[ramAddr]     <= ramData;
                ramWritten[ramAddr] <= 1'b1;
            end else begin
                ramQ <= ramWritten[ramAddr] ? ramMem[ramAddr] : initVal(ramAddr);
            end
        end
    end

    int passCount = 0;
    int checkCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            passCount++;
    endtask

    // Reference model state: expected outputs for the cycle after the next edge.
    logic [7:0] modelMem [1024];
    bit         eAckA, eAckB, eValidA, eValidB, eCen, eWe;
    logic [9:0] eAddr;
    logic [7:0] eData, eDoutA, eDoutB;
    bit         mLastB;
    int         pendOwner;
    logic [7:0] pendData;

    task automatic modelStep();
        int winner;
        bit aEl, bEl;
        if (rst) begin
            {eAckA, eAckB, eValidA, eValidB, eCen, eWe} = '0;
            eAddr = '0; eData = '0; eDoutA = '0; eDoutB = '0;
            mLastB = 1'b1; pendOwner = 0;
            return;
        end
        eValidA = (pendOwner == 1);
        eValidB = (pendOwner == 2);
        if (eValidA) eDoutA = pendData;
        if (eValidB) eDoutB = pendData;
        pendOwner = 0;
        aEl = aBus.req && !eAckA;
        bEl = bBus.req && !eAckB;
        winner = 0;
        if (aEl && bEl) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = 1;
`else
            winner = mLastB ? 1 : 2;
`endif
        end else if (aEl) winner = 1;
        else if (bEl) winner = 2;
        eAckA = (winner == 1);
        eAckB = (winner == 2);
        eCen  = (winner != 0);
        eWe   = 1'b0;
        if (winner != 0) begin
            eWe   = (winner == 1) ? aBus.we   : bBus.we;
            eAddr = (winner == 1) ? aBus.addr : bBus.addr;
            eData = (winner == 1) ? aBus.din  : bBus.din;
            mLastB = (winner == 2);
            if (eWe) modelMem[eAddr] = eData;
            else begin
                pendOwner = winner;
                pendData  = modelMem[eAddr];
            end
        end
    endtask

    task automatic applyStimulus(input bit r,
                                 input bit aR, input bit aW, input logic [9:0] aA, input logic [7:0] aD,
                                 input bit bR, input bit bW, input logic [9:0] bA, input logic [7:0] bD);
        rst = r;
        aBus.req = aR; aBus.we = aW; aBus.addr = aA; aBus.din = aD;
        bBus.req = bR; bBus.we = bW; bBus.addr = bA; bBus.din = bD;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("aAck",    aBus.ack,   eAckA);
        checkOutput("bAck",    bBus.ack,   eAckB);
        checkOutput("aValid",  aBus.valid, eValidA);
        checkOutput("bValid",  bBus.valid, eValidB);
        checkOutput("aDout",   aBus.dout,  eDoutA);
        checkOutput("bDout",   bBus.dout,  eDoutB);
        checkOutput("ramCen",  ramCen,     eCen);
        checkOutput("ramWe",   ramWe,      eWe);
        checkOutput("ramAddr", ramAddr,    eAddr);
        checkOutput("ramData", ramData,    eData);
    endtask

    // Random requester: holds a pending request (occasionally withdrawing it), else maybe issues a new one.
    task automatic nextReq(input bit acked, inout bit rq, inout bit w, inout logic [9:0] ad, inout logic [7:0] d);
        if (rq && !acked) begin
            if ($urandom_range(0, 15) == 0) rq = 1'b0;
        end else begin
            rq = ($urandom_range(0, 2) != 0);
            if (rq) begin
                w  = $urandom_range(0, 1);
                ad = 10'($urandom_range(0, 15));
                d  = 8'($urandom);
            end
        end
    endtask

    initial begin
        int ackCntA, ackCntB;
        bit aR, aW, bR, bW, r;
        logic [9:0] aA, bA;
        logic [7:0] aD, bD;

        for (int i = 0; i < 1024; i++) modelMem[i] = initVal(10'(i));

        repeat (3) applyStimulus(1, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00);
        checkOutput("resetCen", ramCen, 0);
        checkOutput("resetAck", {aBus.ack, bBus.ack}, 0);

        applyStimulus(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00);
        checkOutput("firstGrantA", aBus.ack, 1);
        checkOutput("firstGrantAddr", ramAddr, 10'h010);
        applyStimulus(0, 0, 0, 10'h010, 8'h00, 0, 0, 10'h020, 8'h00);
        applyStimulus(0, 0, 0, 10'h010, 8'h00, 0, 0, 10'h020, 8'h00);

        applyStimulus(0, 1, 1, 10'h123, 8'h5A, 0, 0, 10'h000, 8'h00);
        checkOutput("writeAck", aBus.ack, 1);
        checkOutput("writeData", ramData, 8'h5A);
        applyStimulus(0, 0, 1, 10'h123, 8'h5A, 0, 0, 10'h000, 8'h00);
        checkOutput("writeNoValid", aBus.valid, 0);
        applyStimulus(0, 1, 0, 10'h123, 8'h00, 0, 0, 10'h000, 8'h00);
        applyStimulus(0, 0, 0, 10'h123, 8'h00, 0, 0, 10'h000, 8'h00);
        checkOutput("readbackValid", aBus.valid, 1);
        checkOutput("readbackData", aBus.dout, 8'h5A);

        applyStimulus(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);
        ackCntA = 0; ackCntB = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 10'h040, 8'h00, 1, 0, 10'h041, 8'h00);
            ackCntA += int'(aBus.ack);
            ackCntB += int'(bBus.ack);
        end
        checkOutput("contentionAcksA", ackCntA, 4);
        checkOutput("contentionAcksB", ackCntB, 4);
        applyStimulus(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);
        applyStimulus(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);

        applyStimulus(0, 1, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00);
        applyStimulus(0, 0, 0, 10'h3FF, 8'h00, 1, 0, 10'h000, 8'h00);
        checkOutput("routeADout", aBus.dout, 8'hEE);
        applyStimulus(0, 0, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00);
        checkOutput("routeBDout", bBus.dout, 8'h11);
        checkOutput("routeAHeld", aBus.dout, 8'hEE);
        applyStimulus(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);

        applyStimulus(0, 1, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00);
        applyStimulus(1, 0, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00);
        checkOutput("midResetValid", aBus.valid, 0);
        checkOutput("midResetDout", aBus.dout, 0);
        checkOutput("midResetCen", ramCen, 0);
        applyStimulus(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);

        aR = 0; aW = 0; aA = '0; aD = '0;
        bR = 0; bW = 0; bA = '0; bD = '0;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            nextReq(eAckA, aR, aW, aA, aD);
            nextReq(eAckB, bR, bW, bA, bD);
            applyStimulus(r, aR, aW, aA, aD, bR, bW, bA, bD);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
